// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester-side byte handshake bundle for uart_tx_sched
//
// Purpose: carries the N_REQ byte sources' valid/data/ready signals between
// the protocol/report generators and the round-robin UART scheduler.
// Signals:
//   req_valid [N_REQ]    requester i has a byte on req_dat[8i+7:8i]
//   req_dat   [8*N_REQ]  packed request bytes
//   req_ready [N_REQ]    one-cycle pulse: byte of requester i accepted
// Modports:
//   master  byte sources (drive valid/data, observe ready)
//   slave   scheduler (observes valid/data, drives ready)
interface uart_tx_sched_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_dat;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_dat, input req_ready);
  modport slave  (input req_valid, input req_dat, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_send among N_REQ byte sources
//
// Purpose: grants requesters in strict round-robin order, presents the granted
// byte to uart_send on in_dat/in_flag, waits for busy to rise and fall, holds an
// inter-byte gap of GAP_CYC cycles, then arbitrates again.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to abandon a byte (pulse
// err_to) when busy fails to rise within BUSY_TO cycles of entering WAIT_HI.
// Ports:
//   sys_clk     in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   req         if   requester handshake (slave modport)
//   in_dat      out  byte to uart_send, held from SETUP until the next capture
//   in_flag     out  one-cycle start strobe to uart_send
//   busy        in   uart_send busy
//   grant_id    out  index of requester currently being served
//   sched_busy  out  high whenever the scheduler is not IDLE
//   err_to      out  one-cycle pulse on busy-rise timeout (0 without the macro)
module uart_tx_sched #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int GAP_CYC = 4,
  parameter int BUSY_TO = 64
) (
  input  logic             sys_clk,
  input  logic             rst,
  uart_tx_sched_if.slave   req,
  output logic [7:0]       in_dat,
  output logic             in_flag,
  input  logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             sched_busy,
  output logic             err_to
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam int                GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int                GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_LAST_I);
  localparam logic [ID_W-1:0]   LAST_RST   = ID_W'(N_REQ - 1);
  // With no gap configured the frame ends straight back in IDLE.
  localparam state_t            AFTER_FRAME = (GAP_CYC == 0) ? IDLE : GAP;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        in_dat_q, in_dat_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [7:0]        pick_dat;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int               TO_W    = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BUSY_TO);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`endif

  // Round-robin pick: each valid requester gets its distance after
  // last_grant (0 = immediately after); the smallest distance wins.
  always_comb begin
    int best_d;
    best_d   = N_REQ;
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int d;
      d = (i + N_REQ - 1 - int'(last_grant_q)) % N_REQ;
      if (req.req_valid[i] && (d < best_d)) begin
        best_d   = d;
        pick_vld = 1'b1;
        pick_id  = ID_W'(i);
        pick_dat = req.req_dat[8*i +: 8];
      end
    end
  end

  // Ready is a combinational accept; suppressed while reset is asserted so a
  // reset never acknowledges a byte that will not be sent.
  always_comb begin
    req.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req.req_ready[i] = (state_q == IDLE) && pick_vld && !rst && (pick_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    in_dat_d     = in_dat_q;
    gap_cnt_d    = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_cnt_d     = '0;
    err_to       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_id;
          in_dat_d   = pick_dat;
          state_d    = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = WAIT_HI;
      WAIT_HI: begin
        // busy already high on entry is accepted; glitches before this are ignored
        if (busy) begin
          state_d = WAIT_LO;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          // The byte is dropped, not retried; the requester loses its turn.
          err_to       = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = AFTER_FRAME;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      WAIT_LO: begin
        if (!busy) begin
          last_grant_d = grant_id_q;
          state_d      = AFTER_FRAME;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_id_q   <= '0;
      in_dat_q     <= '0;
      gap_cnt_q    <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      in_dat_q     <= in_dat_d;
      gap_cnt_q    <= gap_cnt_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

`ifndef UART_TX_SCHED_TIMEOUT_EN
  // Without the timeout there is no error source; the comparison folds to 0
  // and only keeps BUSY_TO referenced in this build.
  assign err_to = (BUSY_TO < 0);
`endif

  assign in_dat     = in_dat_q;
  assign in_flag    = (state_q == STROBE);
  assign grant_id   = grant_id_q;
  assign sched_busy = (state_q != IDLE);

endmodule
